// File: rtl/pll_clk_domain_seq.sv
// -----------------------------------------------------------------------------
// pll_clk_domain_seq
//
// Lives in the 16.384 MHz master-PLL output domain. Qualifies the PLL lock
// flag, holds the acoustics domain in reset until lock has been stable for
// LOCK_HOLD cycles, then generates ADC frame timing (bit clock, frame sync,
// sample strobe). Loss of lock re-applies reset at once, discards any partial
// frame and bumps a saturating loss counter.
//
// Ports
//   clk            in   16.384 MHz PLL output clock
//   rst_n          in   synchronous reset, active low
//   pll_locked     in   PLL locked flag (asynchronous to clk)
//   enable         in   frame timing enable, only honoured in RUN
//   sys_rst_n      out  registered domain reset, active low (high only in RUN)
//   ready          out  1 while in RUN
//   bclk           out  ADC bit clock, BCLK_DIV clk per period, first half high
//   fsync          out  high for the first bclk period of each frame
//   sample_stb     out  1-cycle pulse on the last clk of each frame
//   frame_cnt      out  frames completed, 16-bit wrapping
//   lock_loss_cnt  out  RUN -> WAIT_LOCK transitions, saturating
//   state          out  0 WAIT_LOCK, 1 HOLD, 2 RUN
// -----------------------------------------------------------------------------
module pll_clk_domain_seq #(
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned FRAME_DIV = 256,
    parameter int unsigned BCLK_DIV  = 4,
    parameter int unsigned LOSS_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              enable,
    output logic              sys_rst_n,
    output logic              ready,
    output logic              bclk,
    output logic              fsync,
    output logic              sample_stb,
    output logic [15:0]       frame_cnt,
    output logic [LOSS_W-1:0] lock_loss_cnt,
    output logic [1:0]        state
);

    localparam int unsigned HW = (LOCK_HOLD > 2) ? $clog2(LOCK_HOLD) : 1;
    localparam int unsigned PW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    // Lock synchroniser
    logic r_sync1;
    logic r_locked_s;

    // Control FSM
    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_loss_evt;

    // Frame timing
    logic          r_active;
    logic          w_active_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          w_bclk_nxt;
    logic          w_fsync_nxt;
    logic          w_stb_nxt;

    // Registered outputs
    logic              r_sys_rst_n;
    logic              r_ready;
    logic              r_bclk;
    logic              r_fsync;
    logic              r_stb;
    logic [15:0]       r_frame_cnt;
    logic [LOSS_W-1:0] r_loss_cnt;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        w_loss_evt  = 1'b0;
        unique case (r_state)
            S_WAIT_LOCK: begin
                if (r_locked_s) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_hold_cnt == HW'(LOCK_HOLD - 1)) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_loss_evt  = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT_LOCK;
        endcase
    end

    // Phase-derived outputs are registered from the next phase so that they
    // line up with the phase held in r_phase on the same cycle. A freshly
    // activated frame (r_active low) always starts from phase 0.
    always_comb begin
        w_active_nxt = (w_state_nxt == S_RUN) && enable;
        w_phase_nxt  = '0;
        if (w_active_nxt && r_active && (r_phase != PW'(FRAME_DIV - 1))) begin
            w_phase_nxt = r_phase + 1'b1;
        end
        w_bclk_nxt  = w_active_nxt && ((32'(w_phase_nxt) % BCLK_DIV) < (BCLK_DIV / 2));
        w_fsync_nxt = w_active_nxt && (32'(w_phase_nxt) < BCLK_DIV);
        w_stb_nxt   = w_active_nxt && (w_phase_nxt == PW'(FRAME_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= S_WAIT_LOCK;
            r_hold_cnt  <= '0;
            r_active    <= 1'b0;
            r_phase     <= '0;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_bclk      <= 1'b0;
            r_fsync     <= 1'b0;
            r_stb       <= 1'b0;
            r_frame_cnt <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_sync1     <= pll_locked;
            r_locked_s  <= r_sync1;
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_active    <= w_active_nxt;
            r_phase     <= w_phase_nxt;
            r_sys_rst_n <= (w_state_nxt == S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_bclk      <= w_bclk_nxt;
            r_fsync     <= w_fsync_nxt;
            r_stb       <= w_stb_nxt;
            if (w_stb_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_loss_evt && (r_loss_cnt != '1)) r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign sys_rst_n     = r_sys_rst_n;
    assign ready         = r_ready;
    assign bclk          = r_bclk;
    assign fsync         = r_fsync;
    assign sample_stb    = r_stb;
    assign frame_cnt     = r_frame_cnt;
    assign lock_loss_cnt = r_loss_cnt;
    assign state         = r_state;

endmodule
